serial_slice_adder: RTL
=======================

// Module: serial_slice_adder
// PURPOSE
//  Sequential WIDTH-bit adder built around one 2-bit slice: {c1,s1,s0} = a[1:0]+b[1:0]+c0.
//  Feeds the slice 2 operand bits per cycle, LSB pair first, and registers its carry between cycles.
//  Collects the slice sum bits into the result register.
//  Sits between the operand source and result consumer; trades latency for a single 2-bit cell.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be even and >= 2
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  operand A, captured on accepted start
//  b      in   WIDTH  operand B, captured on accepted start
//  cin    in   1      carry-in, captured on accepted start
//  busy   out  1      high while in ADD
//  done   out  1      one-cycle pulse, high while in DONE
//  sum    out  WIDTH  result; valid from DONE, held until next accepted start
//  cout   out  1      final carry-out; same validity as sum
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE; busy=0, done=0, sum=0, cout=0
//   - operand shift regs, carry reg and slice counter cleared
//   - Reset mid-ADD abandons the operation; no done pulse
//  FSM:
//   - IDLE -> ADD on start=1; load a, b, carry<=cin, cnt<=0, sum<=0
//   - ADD (each edge): slice takes shA[1:0], shB[1:0], carry
//     - sum <= {s1,s0,sum[WIDTH-1:2]}; shA,shB >>= 2; carry <= c1; cnt++
//     - on the edge where cnt==WIDTH/2-1, go to DONE and load cout<=c1
//   - DONE -> IDLE unconditionally after one cycle
//  Latency:
//   - exactly WIDTH/2 ADD cycles; done is high in cycle WIDTH/2+1 after the start edge
//   - no idle cycle needed between operations
//  Start handling:
//   - ignored in ADD and DONE, with no queuing
//   - a/b/cin may change freely after the accepting edge
//  Arithmetic: {cout,sum} = a + b + cin, unsigned modulo 2^(WIDTH+1); no saturation
//  Boundaries:
//   - all-ones + cin=1 must ripple carry through every slice
//   - WIDTH=2 completes in one ADD cycle
//   - cnt width = clog2(WIDTH/2), minimum 1 bit; cnt does not wrap inside an operation
// CONFIGURATION
//  SSA_OVF_EN defined:
//   - extra port ovf out 1 = signed two's-complement overflow
//   - ovf = carry-into-bit-(WIDTH-1) XOR cout, from the final slice's internal bit-0 carry
//   - ovf is set with cout, follows cout validity, and resets to 0
//  SSA_OVF_EN undefined: no ovf port and no overflow logic
// TESTING
//  - Reset: rst=1 mid-ADD (cycle 2) -> outputs 0 and IDLE immediately; no done; next start runs cleanly
//  - WIDTH=2: a=2'b11, b=2'b10, cin=1 -> sum=2'b10, cout=1, done 2 cycles after start edge
//  - WIDTH=8: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; busy for 4 cycles, then done for 1 cycle
//  - WIDTH=8: a=8'hA5, b=8'h3C, cin=1 -> sum=8'hE2, cout=0
//  - start held high through ADD with new a/b -> first result unchanged; new op accepted only after return to IDLE
//  - SSA_OVF_EN, WIDTH=8: 8'h7F+8'h01 -> ovf=1, cout=0; 8'h80+8'h80 -> ovf=1, cout=1, sum=0

Source files
------------

// File: rtl/serial_slice_adder.sv
// Sequential WIDTH-bit adder that reuses a single 2-bit full-adder slice, LSB pair first.
// Define SSA_OVF_EN to add the o_ovf port (signed two's-complement overflow of the result).
module serial_slice_adder #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
`ifdef SSA_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("serial_slice_adder: WIDTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sha;
    logic [WIDTH-1:0] r_shb;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_sum_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             w_s0;
    logic             w_c0;
    logic             w_s1;
    logic             w_c1;
    logic             w_last;

    // The one 2-bit slice; w_c0 is the internal carry between its two bit positions.
    assign w_s0 = r_sha[0] ^ r_shb[0] ^ r_carry;
    assign w_c0 = (r_sha[0] & r_shb[0]) | (r_carry & (r_sha[0] ^ r_shb[0]));
    assign w_s1 = r_sha[1] ^ r_shb[1] ^ w_c0;
    assign w_c1 = (r_sha[1] & r_shb[1]) | (w_c0 & (r_sha[1] ^ r_shb[1]));

    assign w_last = (r_cnt == CW'(HALF - 1));

    generate
        if (WIDTH == 2) begin : g_sum_w2
            assign w_sum_nxt = {w_s1, w_s0};
        end else begin : g_sum_wn
            assign w_sum_nxt = {w_s1, w_s0, r_sum[WIDTH-1:2]};
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_ADD;
            S_ADD:   if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == S_ADD);
        o_done = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sha   <= '0;
            r_shb   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sha   <= i_a;
                        r_shb   <= i_b;
                        r_carry <= i_cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_ADD: begin
                    r_sum   <= w_sum_nxt;
                    r_sha   <= r_sha >> 2;
                    r_shb   <= r_shb >> 2;
                    r_carry <= w_c1;
                    // Counter parks on the final slice so it never wraps mid-operation.
                    if (w_last) r_cout <= w_c1;
                    else        r_cnt  <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SSA_OVF_EN
    logic r_ovf;

    // On the last slice w_c0 is the carry into the sign bit and w_c1 is the carry out of it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_ADD && w_last) begin
            r_ovf <= w_c0 ^ w_c1;
        end
    end

    assign o_ovf = r_ovf;
`endif

    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule
